// File: rtl/branch_retire_queue.sv
// In-order retire queue for the global-history branch predictor: records predicted
// branches, absorbs out-of-order resolutions, and retires them one per cycle into the PHT/GHR update port.
module branch_retire_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [IDX_W-1:0] alloc_pht_index,
  input  logic             alloc_pred_taken,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             flush_in,
  output logic             update_en,
  output logic [IDX_W-1:0] update_PHT_index,
  output logic             branch_en,
  output logic             mispredict,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [DEPTH-1:0] pred_q, act_q;
  logic [IDX_W-1:0] pht_q [DEPTH];

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             upd_en_q, upd_en_d, mp_q, mp_d, br_q, br_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;

  logic retire_now, retire_mp, alloc_fire, resolve_wr;

  // Retirement is decided purely from registered state, so a resolve needs one edge to land first.
  assign retire_now  = valid_q[head_q] && resolved_q[head_q];
  assign retire_mp   = retire_now && (pred_q[head_q] != act_q[head_q]);
  assign alloc_ready = (count_q != FULL_CNT) && !retire_mp && !flush_in;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign resolve_wr  = resolve_valid && valid_q[resolve_tag] && !flush_in && !retire_mp;

  assign alloc_tag        = tail_q;
  assign count            = count_q;
  assign update_en        = upd_en_q;
  assign mispredict       = mp_q;
  assign update_PHT_index = upd_idx_q;
  assign branch_en        = br_q;

  always_comb begin
    // NOTE: every target gets a default before any branch so no latch is inferred.
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    upd_en_d   = 1'b0;
    mp_d       = 1'b0;
    upd_idx_d  = upd_idx_q;
    br_d       = br_q;

    if (flush_in) begin
      valid_d    = '0;
      resolved_d = '0;
      tail_d     = head_q;
      count_d    = '0;
    end else if (retire_mp) begin
      // Everything younger than the mispredicted head is on the wrong path.
      valid_d    = '0;
      resolved_d = '0;
      head_d     = head_q + PTR_ONE;
      tail_d     = head_q + PTR_ONE;
      count_d    = '0;
      upd_en_d   = 1'b1;
      mp_d       = 1'b1;
      upd_idx_d  = pht_q[head_q];
      br_d       = act_q[head_q];
    end else begin
      if (resolve_wr) resolved_d[resolve_tag] = 1'b1;
      if (retire_now) begin
        valid_d[head_q]    = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + PTR_ONE;
        upd_en_d           = 1'b1;
        upd_idx_d          = pht_q[head_q];
        br_d               = act_q[head_q];
      end
      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + PTR_ONE;
      end
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_now);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
      upd_en_q   <= 1'b0;
      mp_q       <= 1'b0;
      upd_idx_q  <= '0;
      br_q       <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      upd_en_q   <= upd_en_d;
      mp_q       <= mp_d;
      upd_idx_q  <= upd_idx_d;
      br_q       <= br_d;
    end
  end

  // NOTE: payload storage is not reset; it is only ever read behind a valid/resolved bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pht_q[tail_q]  <= alloc_pht_index;
      pred_q[tail_q] <= alloc_pred_taken;
    end
    if (resolve_wr) act_q[resolve_tag] <= resolve_taken;
  end

endmodule

// File: tb/tb_branch_retire_queue.sv
// Directed bench for branch_retire_queue: expected retirements go into a scoreboard
// queue and a negedge monitor compares every update pulse against it.
module tb_branch_retire_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int IDX_W = 7;

  logic             clk;
  logic             reset;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_pht_index;
  logic             alloc_pred_taken;
  logic [TAG_W-1:0] alloc_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             flush_in;
  logic             update_en;
  logic [IDX_W-1:0] update_PHT_index;
  logic             branch_en;
  logic             mispredict;
  logic [TAG_W:0]   count;

  branch_retire_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_pht_index  (alloc_pht_index),
    .alloc_pred_taken (alloc_pred_taken),
    .alloc_tag        (alloc_tag),
    .resolve_valid    (resolve_valid),
    .resolve_tag      (resolve_tag),
    .resolve_taken    (resolve_taken),
    .flush_in         (flush_in),
    .update_en        (update_en),
    .update_PHT_index (update_PHT_index),
    .branch_en        (branch_en),
    .mispredict       (mispredict),
    .count            (count)
  );

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic             mp;
  } upd_t;

  upd_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    upd_t e;
    if (update_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_update: got idx 0x%0h taken %0b mp %0b, none expected at %0t",
                 update_PHT_index, branch_en, mispredict, $time);
      end else begin
        e = exp_q.pop_front();
        check("upd_pht_index", 32'(update_PHT_index), 32'(e.idx));
        check("upd_branch_en", 32'(branch_en), 32'(e.taken));
        check("upd_mispredict", 32'(mispredict), 32'(e.mp));
      end
    end else if (mispredict === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL lone_mispredict: got mispredict 1 with update_en 0 at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [IDX_W-1:0] idx, input logic pred, input logic [TAG_W-1:0] exp_tag);
    alloc_valid      = 1'b1;
    alloc_pht_index  = idx;
    alloc_pred_taken = pred;
    #1;
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken);
    resolve_valid = 1'b1;
    resolve_tag   = tag;
    resolve_taken = taken;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic taken, input logic mp);
    upd_t e;
    e.idx   = idx;
    e.taken = taken;
    e.mp    = mp;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; alloc_valid = 1'b0; alloc_pht_index = '0; alloc_pred_taken = 1'b0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0; flush_in = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_update_en", 32'(update_en), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_pht_index", 32'(update_PHT_index), 32'd0);
    check("rst_branch_en", 32'(branch_en), 32'd0);

    // Fill, then a refused ninth allocation.
    for (int i = 0; i < DEPTH; i++) alloc(IDX_W'(i), 1'b1, TAG_W'(i));
    check("full_count", 32'(count), 32'd8);
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b1; alloc_pht_index = 7'h7f;
    tick();
    alloc_valid = 1'b0;
    check("refused_count", 32'(count), 32'd8);
    do_reset();
    check("fill_reset_count", 32'(count), 32'd0);

    // Out-of-order resolve, in-order retire.
    alloc(7'h10, 1'b1, 3'd0);
    alloc(7'h11, 1'b1, 3'd1);
    alloc(7'h12, 1'b1, 3'd2);
    resolve(3'd2, 1'b1);
    resolve(3'd1, 1'b1);
    check("ooo_no_early_retire", 32'(update_en), 32'd0);
    check("ooo_count3", 32'(count), 32'd3);
    push(7'h10, 1'b1, 1'b0);
    push(7'h11, 1'b1, 1'b0);
    push(7'h12, 1'b1, 1'b0);
    resolve(3'd0, 1'b1);
    check("ooo_latency_e", 32'(update_en), 32'd0);
    tick();
    check("ooo_latency_e1", 32'(update_en), 32'd1);
    check("ooo_first_idx", 32'(update_PHT_index), 32'h10);
    tick();
    check("ooo_second_idx", 32'(update_PHT_index), 32'h11);
    tick();
    check("ooo_third_idx", 32'(update_PHT_index), 32'h12);
    tick();
    check("ooo_drained_en", 32'(update_en), 32'd0);
    check("ooo_drained_count", 32'(count), 32'd0);

    // Mispredict flush.
    do_reset();
    alloc(7'h15, 1'b0, 3'd0);
    alloc(7'h20, 1'b0, 3'd1);
    alloc(7'h21, 1'b0, 3'd2);
    alloc(7'h22, 1'b0, 3'd3);
    push(7'h15, 1'b1, 1'b1);
    resolve(3'd0, 1'b1);
    alloc_valid = 1'b1; alloc_pht_index = 7'h33; alloc_pred_taken = 1'b0;
    #1;
    check("mp_alloc_ready", 32'(alloc_ready), 32'd0);
    tick();
    alloc_valid = 1'b0;
    check("mp_update_en", 32'(update_en), 32'd1);
    check("mp_mispredict", 32'(mispredict), 32'd1);
    check("mp_pht_index", 32'(update_PHT_index), 32'h15);
    check("mp_count", 32'(count), 32'd0);
    check("mp_tail", 32'(alloc_tag), 32'd1);
    resolve(3'd1, 1'b0);
    resolve(3'd2, 1'b0);
    resolve(3'd3, 1'b0);
    tick();
    tick();
    check("mp_after_count", 32'(count), 32'd0);
    check("mp_after_update_en", 32'(update_en), 32'd0);

    // Pointer wrap with simultaneous alloc and retire.
    base = 1;
    for (int n = 0; n < 22; n++) begin
      alloc_valid      = 1'b1;
      alloc_pht_index  = IDX_W'(8'h30 + n);
      alloc_pred_taken = 1'b1;
      if (n > 0) begin
        resolve_valid = 1'b1;
        resolve_tag   = TAG_W'((base + n - 1) % DEPTH);
        resolve_taken = 1'b1;
        push(IDX_W'(8'h30 + n - 1), 1'b1, 1'b0);
      end
      #1;
      check("wrap_alloc_ready", 32'(alloc_ready), 32'd1);
      check("wrap_alloc_tag", 32'(alloc_tag), 32'((base + n) % DEPTH));
      tick();
      if (n >= 1) check("wrap_count", 32'(count), 32'd2);
    end
    alloc_valid = 1'b0;
    push(IDX_W'(8'h30 + 21), 1'b1, 1'b0);
    resolve(TAG_W'((base + 21) % DEPTH), 1'b1);
    tick();
    tick();
    check("wrap_drained_count", 32'(count), 32'd0);
    check("wrap_tail", 32'(alloc_tag), 32'((base + 22) % DEPTH));

    // External flush against a ready-to-retire head.
    alloc(7'h55, 1'b1, 3'd7);
    alloc(7'h56, 1'b1, 3'd0);
    resolve(3'd7, 1'b1);
    flush_in = 1'b1; alloc_valid = 1'b1; alloc_pht_index = 7'h57;
    #1;
    check("flush_alloc_ready", 32'(alloc_ready), 32'd0);
    tick();
    flush_in = 1'b0; alloc_valid = 1'b0;
    #1;
    check("flush_update_en", 32'(update_en), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_alloc_ready_next", 32'(alloc_ready), 32'd1);
    check("flush_tail", 32'(alloc_tag), 32'd7);
    tick();
    check("flush_quiet", 32'(update_en), 32'd0);

    // Reset mid-operation.
    alloc(7'h60, 1'b1, 3'd7);
    alloc(7'h61, 1'b1, 3'd0);
    alloc(7'h62, 1'b1, 3'd1);
    alloc(7'h63, 1'b1, 3'd2);
    alloc(7'h64, 1'b1, 3'd3);
    resolve(3'd0, 1'b1);
    resolve(3'd1, 1'b1);
    check("midrst_count5", 32'(count), 32'd5);
    do_reset();
    check("midrst_update_en", 32'(update_en), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    alloc(7'h70, 1'b1, 3'd0);
    tick();
    tick();
    check("midrst_new_count", 32'(count), 32'd1);
    check("midrst_update_quiet", 32'(update_en), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
